io_port_responder: RTL and testbench

- Peripheral-side responder for the Core's port I/O handshake. Answers Core in_req/out_req with in_ack/out_ack.
- Holds 2**PA_WIDTH one-deep input mailboxes, filled by the external side and read by the Core.
- Holds 2**PA_WIDTH one-deep output mailboxes, written by the Core and drained by the external side.
- Sits between Core and the testbench/external I/O models; both handshakes are 4-phase.

---
 rtl/io_port_responder.sv | 132 +++++++++++++
 tb/tb_io_port_responder.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_port_responder.sv
// Port I/O responder: two independent 4-phase handshake FSMs (Core read/write)
// in front of per-port one-deep input and output mailboxes.
module io_port_responder #(
  parameter int D_WIDTH   = 34,
  parameter int PA_WIDTH  = 4,
  parameter int ACK_DELAY = 2
) (
  input  logic                clock,
  input  logic                reset_n_i,
  input  logic                in_req_i,
  input  logic [PA_WIDTH-1:0] in_addr_i,
  output logic                in_ack_o,
  output logic [D_WIDTH-1:0]  in_data_o,
  input  logic                out_req_i,
  input  logic [PA_WIDTH-1:0] out_addr_i,
  input  logic [D_WIDTH-1:0]  out_data_i,
  output logic                out_ack_o,
  input  logic                ext_wr_en_i,
  input  logic [PA_WIDTH-1:0] ext_wr_addr_i,
  input  logic [D_WIDTH-1:0]  ext_wr_data_i,
  output logic                ext_wr_ovf_o,
  input  logic                ext_rd_en_i,
  input  logic [PA_WIDTH-1:0] ext_rd_addr_i,
  output logic [D_WIDTH-1:0]  ext_rd_data_o,
  output logic                ext_rd_valid_o
);
  localparam int NPORT = 1 << PA_WIDTH;
  localparam logic [3:0] DLY = 4'(ACK_DELAY);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_e;

  state_e rd_state_q, rd_state_d, wr_state_q, wr_state_d;
  logic [PA_WIDTH-1:0] rd_addr_q, wr_addr_q;
  logic [D_WIDTH-1:0]  wr_data_q, in_data_q, ext_rd_data_q;
  logic [3:0]          rd_cnt_q, wr_cnt_q;
  logic [NPORT-1:0]    in_full_q, in_full_d, out_valid_q, out_valid_d;
  logic                ovf_q, rd_vld_q;
  logic [D_WIDTH-1:0]  in_mem  [NPORT];
  logic [D_WIDTH-1:0]  out_mem [NPORT];

  logic rd_fire, wr_fire, fill_ok, drain_ok;

  // Flags are sampled pre-edge, so a fill racing a consume on one port overflows.
  assign rd_fire  = (rd_state_q == S_WAIT) && (rd_cnt_q == '0) && in_full_q[rd_addr_q];
  assign wr_fire  = (wr_state_q == S_WAIT) && (wr_cnt_q == '0) && !out_valid_q[wr_addr_q];
  assign fill_ok  = ext_wr_en_i && !in_full_q[ext_wr_addr_i];
  assign drain_ok = ext_rd_en_i && out_valid_q[ext_rd_addr_i];

  always_comb begin
    rd_state_d = rd_state_q;
    case (rd_state_q)
      S_IDLE:  if (in_req_i) rd_state_d = S_WAIT;
      S_WAIT:  if (rd_fire) rd_state_d = S_ACK;
      S_ACK:   if (!in_req_i) rd_state_d = S_IDLE;
      default: rd_state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wr_state_d = wr_state_q;
    case (wr_state_q)
      S_IDLE:  if (out_req_i) wr_state_d = S_WAIT;
      S_WAIT:  if (wr_fire) wr_state_d = S_ACK;
      S_ACK:   if (!out_req_i) wr_state_d = S_IDLE;
      default: wr_state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_full_d   = in_full_q;
    out_valid_d = out_valid_q;
    if (rd_fire)  in_full_d[rd_addr_q] = 1'b0;
    if (fill_ok)  in_full_d[ext_wr_addr_i] = 1'b1;
    if (wr_fire)  out_valid_d[wr_addr_q] = 1'b1;
    if (drain_ok) out_valid_d[ext_rd_addr_i] = 1'b0;
  end

  always_ff @(posedge clock or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rd_state_q    <= S_IDLE;
      wr_state_q    <= S_IDLE;
      rd_addr_q     <= '0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      rd_cnt_q      <= '0;
      wr_cnt_q      <= '0;
      in_data_q     <= '0;
      ext_rd_data_q <= '0;
      in_full_q     <= '0;
      out_valid_q   <= '0;
      ovf_q         <= 1'b0;
      rd_vld_q      <= 1'b0;
    end else begin
      rd_state_q  <= rd_state_d;
      wr_state_q  <= wr_state_d;
      in_full_q   <= in_full_d;
      out_valid_q <= out_valid_d;
      ovf_q       <= ext_wr_en_i && in_full_q[ext_wr_addr_i];
      rd_vld_q    <= drain_ok;
      if (rd_state_q == S_IDLE && in_req_i) begin
        rd_addr_q <= in_addr_i;
        rd_cnt_q  <= DLY;
      end else if (rd_state_q == S_WAIT && rd_cnt_q != '0) begin
        rd_cnt_q <= rd_cnt_q - 4'd1;
      end
      if (wr_state_q == S_IDLE && out_req_i) begin
        wr_addr_q <= out_addr_i;
        wr_data_q <= out_data_i;
        wr_cnt_q  <= DLY;
      end else if (wr_state_q == S_WAIT && wr_cnt_q != '0) begin
        wr_cnt_q <= wr_cnt_q - 4'd1;
      end
      if (rd_fire)  in_data_q     <= in_mem[rd_addr_q];
      if (drain_ok) ext_rd_data_q <= out_mem[ext_rd_addr_i];
    end
  end

  // Mailbox storage carries no reset; the flags alone define occupancy.
  always_ff @(posedge clock) begin
    if (fill_ok) in_mem[ext_wr_addr_i] <= ext_wr_data_i;
    if (wr_fire) out_mem[wr_addr_q]    <= wr_data_q;
  end

  always_comb begin
    in_ack_o       = (rd_state_q == S_ACK);
    out_ack_o      = (wr_state_q == S_ACK);
    in_data_o      = in_data_q;
    ext_rd_data_o  = ext_rd_data_q;
    ext_wr_ovf_o   = ovf_q;
    ext_rd_valid_o = rd_vld_q;
  end
endmodule

// File: tb/tb_io_port_responder.sv
// Bench for io_port_responder: directed scenarios plus random mailbox traffic
// checked against an array-based model of the mailboxes.
module tb_io_port_responder;
  localparam int DW = 34;
  localparam int AW = 4;
  localparam int NP = 16;
  localparam int DLY = 2;
  localparam int LAT = DLY + 2;  // steps from raising req (incl. sampling edge) to ack

  logic          clock = 1'b0;
  logic          reset_n_i;
  logic          in_req_i = 0, out_req_i = 0, ext_wr_en_i = 0, ext_rd_en_i = 0;
  logic [AW-1:0] in_addr_i = '0, out_addr_i = '0, ext_wr_addr_i = '0, ext_rd_addr_i = '0;
  logic [DW-1:0] out_data_i = '0, ext_wr_data_i = '0;
  logic          in_ack_o, out_ack_o, ext_wr_ovf_o, ext_rd_valid_o;
  logic [DW-1:0] in_data_o, ext_rd_data_o;

  io_port_responder #(.D_WIDTH(DW), .PA_WIDTH(AW), .ACK_DELAY(DLY)) dut (
    .clock(clock), .reset_n_i(reset_n_i),
    .in_req_i(in_req_i), .in_addr_i(in_addr_i), .in_ack_o(in_ack_o), .in_data_o(in_data_o),
    .out_req_i(out_req_i), .out_addr_i(out_addr_i), .out_data_i(out_data_i), .out_ack_o(out_ack_o),
    .ext_wr_en_i(ext_wr_en_i), .ext_wr_addr_i(ext_wr_addr_i), .ext_wr_data_i(ext_wr_data_i),
    .ext_wr_ovf_o(ext_wr_ovf_o),
    .ext_rd_en_i(ext_rd_en_i), .ext_rd_addr_i(ext_rd_addr_i), .ext_rd_data_o(ext_rd_data_o),
    .ext_rd_valid_o(ext_rd_valid_o)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  logic          in_full_m  [NP];
  logic [DW-1:0] in_mem_m   [NP];
  logic          out_valid_m[NP];
  logic [DW-1:0] out_mem_m  [NP];

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic model_clear;
    for (int i = 0; i < NP; i++) begin
      in_full_m[i] = 1'b0;
      out_valid_m[i] = 1'b0;
    end
  endtask

  task automatic do_fill(input int p, input logic [DW-1:0] d);
    logic exp_ovf;
    exp_ovf = in_full_m[p];
    ext_wr_en_i = 1; ext_wr_addr_i = AW'(p); ext_wr_data_i = d;
    step;
    ext_wr_en_i = 0;
    checks++;
    if (ext_wr_ovf_o !== exp_ovf) begin
      errors++; $display("FAIL fill_ovf port %0d: got %b want %b", p, ext_wr_ovf_o, exp_ovf);
    end
    if (!exp_ovf) begin in_full_m[p] = 1'b1; in_mem_m[p] = d; end
  endtask

  task automatic do_drain(input int p);
    ext_rd_en_i = 1; ext_rd_addr_i = AW'(p);
    step;
    ext_rd_en_i = 0;
    checks++;
    if (ext_rd_valid_o !== out_valid_m[p]) begin
      errors++; $display("FAIL drain_valid port %0d: got %b want %b", p, ext_rd_valid_o, out_valid_m[p]);
    end
    if (out_valid_m[p]) begin
      checks++;
      if (ext_rd_data_o !== out_mem_m[p]) begin
        errors++; $display("FAIL drain_data port %0d: got %h want %h", p, ext_rd_data_o, out_mem_m[p]);
      end
    end
    out_valid_m[p] = 1'b0;
  endtask

  task automatic do_read(input int p);
    int n = 0;
    in_req_i = 1; in_addr_i = AW'(p);
    while (!in_ack_o && n < 50) begin step; n++; end
    checks++;
    if (n != LAT) begin
      errors++; $display("FAIL read_latency port %0d: got %0d want %0d", p, n, LAT);
    end
    checks++;
    if (in_data_o !== in_mem_m[p]) begin
      errors++; $display("FAIL read_data port %0d: got %h want %h", p, in_data_o, in_mem_m[p]);
    end
    in_full_m[p] = 1'b0;
    in_req_i = 0;
    step;
    checks++;
    if (in_ack_o !== 1'b0) begin
      errors++; $display("FAIL read_ack_drop port %0d: got %b want 0", p, in_ack_o);
    end
  endtask

  task automatic do_write(input int p, input logic [DW-1:0] d);
    int n = 0;
    out_req_i = 1; out_addr_i = AW'(p); out_data_i = d;
    while (!out_ack_o && n < 50) begin step; n++; end
    checks++;
    if (n != LAT) begin
      errors++; $display("FAIL write_latency port %0d: got %0d want %0d", p, n, LAT);
    end
    out_valid_m[p] = 1'b1; out_mem_m[p] = d;
    out_req_i = 0;
    step;
    checks++;
    if (out_ack_o !== 1'b0) begin
      errors++; $display("FAIL write_ack_drop port %0d: got %b want 0", p, out_ack_o);
    end
  endtask

  task automatic test_reset;
    int bad = 0;
    reset_n_i = 0;
    repeat (3) step;
    checks++;
    if ({in_ack_o, out_ack_o, ext_wr_ovf_o, ext_rd_valid_o, in_data_o, ext_rd_data_o} !== '0) begin
      errors++; $display("FAIL reset_outputs: got ack=%b/%b data=%h/%h want all 0",
                         in_ack_o, out_ack_o, in_data_o, ext_rd_data_o);
    end
    reset_n_i = 1;
    model_clear();
    repeat (10) begin
      step;
      if ({in_ack_o, out_ack_o, ext_wr_ovf_o, ext_rd_valid_o, in_data_o, ext_rd_data_o} !== '0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL idle_outputs: got %0d nonzero cycles want 0", bad);
    end
  endtask

  task automatic test_basic_read;
    do_fill(5, 34'h2_DEAD_BEEF);
    do_read(5);
    do_fill(5, 34'h0_0000_0042);  // must not overflow: consume cleared the flag
    do_read(5);
  endtask

  task automatic test_blocking_read;
    int bad = 0;
    in_req_i = 1; in_addr_i = 4'd3;
    repeat (20) begin step; if (in_ack_o !== 1'b0) bad++; end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL blocking_stall: got %0d ack cycles want 0", bad);
    end
    ext_wr_en_i = 1; ext_wr_addr_i = 4'd3; ext_wr_data_i = 34'h1;
    step;
    ext_wr_en_i = 0;
    checks++;
    if (in_ack_o !== 1'b0) begin
      errors++; $display("FAIL blocking_fill_edge: got %b want 0", in_ack_o);
    end
    step;
    checks++;
    if (in_ack_o !== 1'b1 || in_data_o !== 34'h1) begin
      errors++; $display("FAIL blocking_ack: got ack=%b data=%h want 1 %h", in_ack_o, in_data_o, 34'h1);
    end
    in_req_i = 0;
    step;
    checks++;
    if (in_ack_o !== 1'b0) begin
      errors++; $display("FAIL blocking_ack_drop: got %b want 0", in_ack_o);
    end
  endtask

  task automatic test_write_drain;
    do_write(9, 34'h3_0000_0001);
    do_drain(9);
    step;
    checks++;
    if (ext_rd_valid_o !== 1'b0) begin
      errors++; $display("FAIL drain_pulse_width: got %b want 0", ext_rd_valid_o);
    end
    do_drain(9);
  endtask

  task automatic test_write_stall;
    int bad = 0;
    do_write(9, 34'h1_1111_1111);
    out_req_i = 1; out_addr_i = 4'd9; out_data_i = 34'h2_2222_2222;
    repeat (10) begin step; if (out_ack_o !== 1'b0) bad++; end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL write_stall: got %0d ack cycles want 0", bad);
    end
    ext_rd_en_i = 1; ext_rd_addr_i = 4'd9;
    step;
    ext_rd_en_i = 0;
    checks++;
    if (ext_rd_valid_o !== 1'b1 || ext_rd_data_o !== 34'h1_1111_1111 || out_ack_o !== 1'b0) begin
      errors++; $display("FAIL stall_drain: got v=%b d=%h ack=%b want 1 %h 0",
                         ext_rd_valid_o, ext_rd_data_o, out_ack_o, 34'h1_1111_1111);
    end
    step;
    checks++;
    if (out_ack_o !== 1'b1) begin
      errors++; $display("FAIL stall_release: got %b want 1", out_ack_o);
    end
    out_req_i = 0;
    step;
    out_valid_m[9] = 1'b1; out_mem_m[9] = 34'h2_2222_2222;
    do_drain(9);
  endtask

  task automatic test_overflow;
    do_fill(0, 34'h0_AAAA_0001);
    do_fill(0, 34'h3_BBBB_0002);
    step;
    checks++;
    if (ext_wr_ovf_o !== 1'b0) begin
      errors++; $display("FAIL ovf_pulse_width: got %b want 0", ext_wr_ovf_o);
    end
    do_read(0);
  endtask

  task automatic test_random;
    for (int it = 0; it < 60; it++) begin
      int op, p;
      logic [DW-1:0] d;
      op = int'($urandom_range(3, 0));
      p  = int'($urandom_range(NP - 1, 0));
      d  = DW'({$urandom(), $urandom()});
      case (op)
        0: do_fill(p, d);
        1: do_drain(p);
        2: begin if (!in_full_m[p]) do_fill(p, d); do_read(p); end
        default: begin if (out_valid_m[p]) do_drain(p); do_write(p, d); end
      endcase
    end
  endtask

  task automatic test_async_reset;
    int n = 0;
    do_fill(4, 34'h0_4444_4444);
    do_write(2, 34'h0_2222_0000);
    do_fill(7, 34'h0_7777_7777);
    in_req_i = 1; in_addr_i = 4'd7;
    while (!in_ack_o && n < 50) begin step; n++; end
    checks++;
    if (in_ack_o !== 1'b1) begin
      errors++; $display("FAIL areset_setup: got %b want 1", in_ack_o);
    end
    #3 reset_n_i = 0;
    #1;
    checks++;
    if ({in_ack_o, out_ack_o, ext_wr_ovf_o, ext_rd_valid_o, in_data_o, ext_rd_data_o} !== '0) begin
      errors++; $display("FAIL areset_outputs: got ack=%b data=%h want 0 0", in_ack_o, in_data_o);
    end
    in_req_i = 0;
    step; step;
    reset_n_i = 1;
    model_clear();
    step;
    do_fill(4, 34'h0_5555_5555);  // flag cleared by reset: no overflow
    do_drain(2);                  // valid cleared by reset: no pulse
    do_read(4);
  endtask

  initial begin
    test_reset();
    test_basic_read();
    test_blocking_read();
    test_write_drain();
    test_write_stall();
    test_overflow();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
